// File: rtl/shift_normalizer_if.sv
// Handshake and data bundle for shift_normalizer.
// Optional feature macro: SHIFT_NORMALIZER_LIMIT_EN (adds limit/limited).
// Handshake: start is sampled only while busy=0 (IDLE or DONE). done is a
// one-cycle pulse. output/count/zero (and limited) are valid with done and
// hold until the next completion or reset. done and busy are never both high.
interface shift_normalizer_if #(
    parameter int SIZE = 4
);
    localparam int CW = $clog2(SIZE);

    logic            shift_normalizer_port_start;
    logic [SIZE-1:0] shift_normalizer_port_input;
    logic            shift_normalizer_port_direction;
    logic            shift_normalizer_port_busy;
    logic            shift_normalizer_port_done;
    logic [SIZE-1:0] shift_normalizer_port_output;
    logic [CW-1:0]   shift_normalizer_port_count;
    logic            shift_normalizer_port_zero;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
    logic [CW-1:0]   shift_normalizer_port_limit;
    logic            shift_normalizer_port_limited;
`endif
    // FSM state for observation: 0=IDLE, 1=SHIFT, 2=DONE
    logic [1:0]      dbg_state;

    modport master (
        output shift_normalizer_port_start,
        output shift_normalizer_port_input,
        output shift_normalizer_port_direction,
`ifdef SHIFT_NORMALIZER_LIMIT_EN
        output shift_normalizer_port_limit,
        input  shift_normalizer_port_limited,
`endif
        input  shift_normalizer_port_busy,
        input  shift_normalizer_port_done,
        input  shift_normalizer_port_output,
        input  shift_normalizer_port_count,
        input  shift_normalizer_port_zero,
        input  dbg_state
    );

    modport slave (
        input  shift_normalizer_port_start,
        input  shift_normalizer_port_input,
        input  shift_normalizer_port_direction,
`ifdef SHIFT_NORMALIZER_LIMIT_EN
        input  shift_normalizer_port_limit,
        output shift_normalizer_port_limited,
`endif
        output shift_normalizer_port_busy,
        output shift_normalizer_port_done,
        output shift_normalizer_port_output,
        output shift_normalizer_port_count,
        output shift_normalizer_port_zero,
        output dbg_state
    );
endinterface

// File: rtl/shift_normalizer.sv
// shift_normalizer: sequential leading-one normalizer. Shifts a captured word
// one position per clock toward the selected end until the leading 1 reaches
// it, then reports the normalized word, the shift count and an all-zero flag.
// The count can drive a barrel shifter's shift amount directly.
// Optional feature macro: SHIFT_NORMALIZER_LIMIT_EN (caps the shift count).
module shift_normalizer #(
    parameter int SIZE = 4
) (
    input  logic              shift_normalizer_port_clk,
    input  logic              shift_normalizer_port_reset,
    shift_normalizer_if.slave bus
);
    localparam int CW = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic [SIZE-1:0] out_q, out_d;
    logic [CW-1:0]   count_q, count_d;
    logic            zero_q, zero_d;
    logic            target_bit;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
    logic [CW-1:0]   limit_q, limit_d;
    logic            limited_q, limited_d;
`endif

    // The bit that must be 1 for the word to count as normalized.
    assign target_bit = dir_q ? work_q[0] : work_q[SIZE-1];

    // Next-state and datapath: capture on start, shift until normalized.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        out_d   = out_q;
        count_d = count_q;
        zero_d  = zero_q;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
        limit_d   = limit_q;
        limited_d = limited_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start like IDLE so operations can run back to back.
                state_d = IDLE;
                if (bus.shift_normalizer_port_start) begin
                    work_d  = bus.shift_normalizer_port_input;
                    dir_d   = bus.shift_normalizer_port_direction;
                    cnt_d   = '0;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
                    limit_d = bus.shift_normalizer_port_limit;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (work_q == '0) begin
                    out_d   = '0;
                    count_d = '0;
                    zero_d  = 1'b1;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
                    limited_d = 1'b0;
`endif
                    state_d = DONE;
                end else if (target_bit) begin
                    out_d   = work_q;
                    count_d = cnt_q;
                    zero_d  = 1'b0;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
                    limited_d = 1'b0;
`endif
                    state_d = DONE;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
                end else if (cnt_q == limit_q) begin
                    // Cap reached before normalization: report the partial word.
                    out_d     = work_q;
                    count_d   = limit_q;
                    zero_d    = 1'b0;
                    limited_d = 1'b1;
                    state_d   = DONE;
`endif
                end else begin
                    // Counter cannot pass SIZE-1: the leading 1 reaches the end first.
                    work_d = dir_q ? (work_q >> 1) : (work_q << 1);
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-high reset.
    always_ff @(posedge shift_normalizer_port_clk) begin
        if (shift_normalizer_port_reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
            limit_q   <= '0;
            limited_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            count_q <= count_d;
            zero_q  <= zero_d;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
            limit_q   <= limit_d;
            limited_q <= limited_d;
`endif
        end
    end

    assign bus.shift_normalizer_port_busy   = (state_q == SHIFT);
    assign bus.shift_normalizer_port_done   = (state_q == DONE);
    assign bus.shift_normalizer_port_output = out_q;
    assign bus.shift_normalizer_port_count  = count_q;
    assign bus.shift_normalizer_port_zero   = zero_q;
    assign bus.dbg_state                    = state_q;
`ifdef SHIFT_NORMALIZER_LIMIT_EN
    assign bus.shift_normalizer_port_limited = limited_q;
`endif
endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Sequential inverse of the combinational barrel shifter: recovers the shift amount from a word instead of applying one.
- Takes a SIZE-bit word and shifts it one position per clock toward the selected end until the leading 1 reaches that end.
- Reports the normalized word, the number of positions shifted, and an all-zero flag.
- Sits beside the barrel shifter and counter in the datapath. Its count output can feed the barrel shifter's shift input directly to undo or redo a normalization.

Parameters:
- SIZE, 4, data width in bits; power of two, >= 2; count width is $clog2(SIZE).

Ports:
- shift_normalizer_port_clk  input  1  rising-edge clock
- shift_normalizer_port_reset  input  1  synchronous active-high reset
- shift_normalizer_port_start  input  1  begin a normalization; sampled only when busy=0
- shift_normalizer_port_input  input  SIZE  word to normalize; sampled with start
- shift_normalizer_port_direction  input  1  sampled with start; 0 = normalize toward MSB (shift left), 1 = toward LSB (shift right)
- shift_normalizer_port_busy  output  1  high while shifting
- shift_normalizer_port_done  output  1  one-cycle pulse: result, count and zero are valid
- shift_normalizer_port_output  output  SIZE  normalized word
- shift_normalizer_port_count  output  $clog2(SIZE)  positions shifted
- shift_normalizer_port_zero  output  1  input word was all zeros

Behaviour:
- Reset: synchronous, active-high, on the rising edge of shift_normalizer_port_clk.
  - Forces IDLE, from any state including mid-SHIFT; any in-progress operation is discarded, no done pulse.
  - Clears all outputs and internal registers to 0: busy=0, done=0, output=0, count=0, zero=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a clock edge: capture input into the work register and latch direction; clear the counter.
  - Go to SHIFT; busy=1 from the next cycle.
- SHIFT, evaluated on each edge:
  - Work register == 0: zero=1, count=0, output=0, go to DONE.
  - Target bit set: copy work register to output and counter to count, zero=0, go to DONE. Target bit is bit SIZE-1 for direction 0, bit 0 for direction 1.
  - Otherwise: shift the work register 1 position toward the target end, filling with 0, and increment the counter.
  - The counter never exceeds SIZE-1, since the single remaining 1 reaches the end by then; no wrap is possible.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - start=1 while in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
- Latency:
  - With k = final count (0..SIZE-1), done is high in the cycle after the (k+1)th edge following the edge that sampled start.
  - Zero input: done follows after 1 edge, as for k=0.
- Result holding: output, count and zero hold their values after done until the next completion or reset.
- start while busy=1: ignored; input and direction changes are ignored until the operation completes.
- Invariant: done and busy are never high in the same cycle.

Optional Feature:
- Macro: SHIFT_NORMALIZER_LIMIT_EN.
- Defined:
  - Adds input shift_normalizer_port_limit ($clog2(SIZE) bits), sampled with start.
  - Adds output shift_normalizer_port_limited (1 bit; reset 0; held like count).
  - In SHIFT, if the counter equals limit and the target bit is clear and the word is nonzero: stop, output the work register, count=limit, limited=1, go to DONE.
  - Normal completion sets limited=0.
- Undefined: no limit or limited ports; shifting always runs to normalization.

Test Plan (SIZE=4):
- input=0010, dir=0, start pulse -> after 3 edges: done=1 for one cycle, output=1000, count=2, zero=0; busy high during the 2 shifting cycles.
- input=1000, dir=0 -> done after 1 edge, output=1000, count=0. Then input=0000 -> done after 1 edge, output=0000, count=0, zero=1.
- input=0110, dir=1 -> output=0011, count=1. Then input=0001, dir=0 with start re-pulsed and input changed to 1111 while busy -> output=1000, count=3; the mid-operation start is ignored.
- Back-to-back: start held high through DONE with input=0100, dir=1 -> second operation accepted, output=0001, count=2; done never coincides with busy.
- Reset asserted on the 2nd shifting cycle of input=0001, dir=0 -> next cycle all outputs 0, IDLE, no done pulse; a new start then works normally.
- With SHIFT_NORMALIZER_LIMIT_EN, input=0001, dir=0, limit=1 -> output=0010, count=1, limited=1. With limit=3 -> output=1000, count=3, limited=0.
